// File: rtl/interrupt_controller.sv
// Single-level interrupt entry sequencer: synchronizes irq_in, drains the pipeline,
// pushes PC/flags to the stack, vectors the PC, then waits in service until RTI.
module interrupt_controller #(
    parameter logic [31:0] VECTOR_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq_in,
    input  logic        pipe_busy,
    input  logic [31:0] pc_in,
    input  logic [2:0]  flags_in,
    input  logic        push_ack,
    input  logic        rti_done,
    output logic        fetch_stall,
    output logic        interrupt_signal,
    output logic        push_valid,
    output logic [15:0] push_data,
    output logic        pc_load,
    output logic [31:0] pc_vector,
    output logic        in_service,
    output logic [7:0]  dropped_count
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned FLAGS_W = 3;
    localparam int unsigned CNT_W   = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [STATE_W-1:0] IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] DRAIN      = 3'd1;
    localparam logic [STATE_W-1:0] PUSH_HI    = 3'd2;
    localparam logic [STATE_W-1:0] PUSH_LO    = 3'd3;
    localparam logic [STATE_W-1:0] PUSH_FLAGS = 3'd4;
    localparam logic [STATE_W-1:0] VECTOR     = 3'd5;
    localparam logic [STATE_W-1:0] SERVICE    = 3'd6;

    logic               irq_sync1;
    logic               irq_sync2;
    logic               irq_sync2_d;
    logic [1:0]         settle;
    logic               irq_edge_c;
    logic               pending;
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic               capture_c;
    logic [PC_W-1:0]    pc_hold;
    logic [PC_W-1:0]    pc_hold_next;
    logic [FLAGS_W-1:0] flags_hold;
    logic [FLAGS_W-1:0] flags_hold_next;
    logic               fetch_stall_next;
    logic               interrupt_signal_next;
    logic               push_valid_next;
    logic [DATA_W-1:0]  push_data_next;
    logic               pc_load_next;
    logic               in_service_next;

    assign pc_vector  = VECTOR_ADDR;
    assign irq_edge_c = irq_sync2 & ~irq_sync2_d;

    // Edge history is held high until the synchronizer has flushed its reset value,
    // so a level already high at reset release is not mistaken for a new edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_sync1   <= 1'b0;
            irq_sync2   <= 1'b0;
            irq_sync2_d <= 1'b1;
            settle      <= 2'b00;
        end else begin
            irq_sync1   <= irq_in;
            irq_sync2   <= irq_sync1;
            settle      <= {settle[0], 1'b1};
            irq_sync2_d <= settle[1] ? irq_sync2 : 1'b1;
        end
    end

    // One-deep pending request; an edge in the VECTOR cycle re-arms it rather than dropping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending       <= 1'b0;
            dropped_count <= '0;
        end else begin
            if (irq_edge_c) begin
                pending <= 1'b1;
            end else if (state == VECTOR) begin
                pending <= 1'b0;
            end
            if (irq_edge_c && pending && (state != VECTOR) && (dropped_count != CNT_MAX)) begin
                dropped_count <= dropped_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc_hold    <= '0;
            flags_hold <= '0;
        end else begin
            state      <= state_next;
            pc_hold    <= pc_hold_next;
            flags_hold <= flags_hold_next;
        end
    end

    // Next state, hold capture, and output decode of the state being entered.
    always_comb begin
        state_next            = state;
        capture_c             = 1'b0;
        fetch_stall_next      = 1'b0;
        interrupt_signal_next = 1'b0;
        push_valid_next       = 1'b0;
        push_data_next        = '0;
        pc_load_next          = 1'b0;
        in_service_next       = 1'b0;

        case (state)
            IDLE:       if (pending) state_next = DRAIN;
            DRAIN: begin
                if (!pipe_busy) begin
                    state_next = PUSH_HI;
                    capture_c  = 1'b1;
                end
            end
            PUSH_HI:    if (push_ack) state_next = PUSH_LO;
            PUSH_LO:    if (push_ack) state_next = PUSH_FLAGS;
            PUSH_FLAGS: if (push_ack) state_next = VECTOR;
            VECTOR:     state_next = SERVICE;
            SERVICE:    if (rti_done) state_next = IDLE;
            default:    state_next = IDLE;
        endcase

        pc_hold_next    = capture_c ? pc_in    : pc_hold;
        flags_hold_next = capture_c ? flags_in : flags_hold;

        case (state_next)
            DRAIN: fetch_stall_next = 1'b1;
            PUSH_HI: begin
                fetch_stall_next      = 1'b1;
                interrupt_signal_next = 1'b1;
                push_valid_next       = 1'b1;
                push_data_next        = pc_hold_next[PC_W-1:DATA_W];
            end
            PUSH_LO: begin
                fetch_stall_next      = 1'b1;
                interrupt_signal_next = 1'b1;
                push_valid_next       = 1'b1;
                push_data_next        = pc_hold_next[DATA_W-1:0];
            end
            PUSH_FLAGS: begin
                fetch_stall_next      = 1'b1;
                interrupt_signal_next = 1'b1;
                push_valid_next       = 1'b1;
                push_data_next        = DATA_W'(flags_hold_next);
            end
            VECTOR: begin
                fetch_stall_next      = 1'b1;
                interrupt_signal_next = 1'b1;
                pc_load_next          = 1'b1;
            end
            SERVICE: in_service_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_stall      <= 1'b0;
            interrupt_signal <= 1'b0;
            push_valid       <= 1'b0;
            push_data        <= '0;
            pc_load          <= 1'b0;
            in_service       <= 1'b0;
        end else begin
            fetch_stall      <= fetch_stall_next;
            interrupt_signal <= interrupt_signal_next;
            push_valid       <= push_valid_next;
            push_data        <= push_data_next;
            pc_load          <= pc_load_next;
            in_service       <= in_service_next;
        end
    end

endmodule
